alu_vec_fx16: RTL and testbench

//  16-lane SIMD ALU on signed Q8.8 fixed-point (two's complement, 16 bit/lane) vectors packed in 256 bits.

---
 rtl/alu_vec_fx16.sv | 116 +++++++++++
 tb/tb_alu_vec_fx16.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_fx16.sv
// 16-lane SIMD ALU on signed Q8.8 vectors, with a 1-cycle registered result and per-lane NZCV flags.
// All lanes are independent; only the SUM horizontal reduction crosses lanes.
module alu_vec_fx16 #(
  parameter int unsigned LANES = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*16-1:0]   a,
  input  logic [LANES*16-1:0]   b,
  input  logic [15:0]           c,
  input  logic [2:0]            opcode,
  input  logic                  flag_scalar,
  output logic [LANES*16-1:0]   result,
  output logic [LANES*4-1:0]    flags
);

  localparam int unsigned SumW = 16 + $clog2(LANES);

  typedef enum logic [2:0] {
    OpMul = 3'b000,
    OpSub = 3'b001,
    OpAdd = 3'b010,
    OpSum = 3'b011,
    OpMov = 3'b100,
    OpSet = 3'b111
  } op_e;

  logic [LANES*16-1:0] result_d;
  logic [LANES*4-1:0]  flags_d;

  logic signed [15:0]     la;
  logic signed [15:0]     lb;
  logic [15:0]            lr;
  logic signed [31:0]     prod;
  logic [16:0]            wide;
  logic signed [SumW-1:0] hsum;
  logic [16-FRAC:0]       prod_hi;
  logic [SumW-16:0]       hsum_hi;
  logic                   cy;
  logic                   ov;

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    la       = '0;
    lb       = '0;
    lr       = '0;
    prod     = '0;
    wide     = '0;
    prod_hi  = '0;
    cy       = 1'b0;
    ov       = 1'b0;

    // Exact horizontal sum; SumW bits cannot overflow for LANES 16-bit terms.
    hsum = '0;
    for (int i = 0; i < LANES; i++) begin
      hsum = hsum + SumW'($signed(a[16*i +: 16]));
    end
    hsum_hi = hsum[SumW-1:15];

    for (int i = 0; i < LANES; i++) begin
      la      = a[16*i +: 16];
      lb      = flag_scalar ? b[15:0] : b[16*i +: 16];
      lr      = '0;
      cy      = 1'b0;
      ov      = 1'b0;
      prod    = 32'(la) * 32'(lb);
      prod_hi = prod[31:FRAC+15];
      wide    = '0;

      case (opcode)
        OpMul: begin
          lr = prod[FRAC+15:FRAC];
          // Any disagreement above the kept sign bit means the Q result does not fit.
          ov = !((&prod_hi) || (~|prod_hi));
        end
        OpSub: begin
          wide = {1'b0, la} - {1'b0, lb};
          lr   = wide[15:0];
          cy   = wide[16];
          ov   = (la[15] != lb[15]) && (lr[15] != la[15]);
        end
        OpAdd: begin
          wide = {1'b0, la} + {1'b0, lb};
          lr   = wide[15:0];
          cy   = wide[16];
          ov   = (la[15] == lb[15]) && (lr[15] != la[15]);
        end
        OpSum: begin
          if (i == 0) begin
            lr = hsum[15:0];
            ov = !((&hsum_hi) || (~|hsum_hi));
          end
        end
        OpMov:   lr = la;
        OpSet:   lr = c;
        default: lr = '0;
      endcase

      result_d[16*i +: 16] = lr;
      flags_d[4*i +: 4]    = {lr[15], (lr == 16'h0000), cy, ov};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else begin
      result <= result_d;
      flags  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_vec_fx16.sv
// Scoreboard bench for alu_vec_fx16: expected values are queued when stimulus is driven
// and compared one clock later when the registered result appears.
module tb_alu_vec_fx16;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] a;
  logic [255:0] b;
  logic [15:0]  c;
  logic [2:0]   opcode;
  logic         flag_scalar;
  logic [255:0] result;
  logic [63:0]  flags;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [255:0] r;
    logic [63:0]  f;
    string        tag;
  } exp_t;

  exp_t sb[$];

  alu_vec_fx16 dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .c           (c),
    .opcode      (opcode),
    .flag_scalar (flag_scalar),
    .result      (result),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int in_range16(input int v);
    return (v >= -32768 && v <= 32767) ? 1 : 0;
  endfunction

  // Reference model written with plain integer arithmetic.
  function automatic void model(input logic [255:0] va, input logic [255:0] vb,
                                input logic [15:0] vc, input logic [2:0] op, input logic fs,
                                output logic [255:0] r, output logic [63:0] f);
    int          sa, sb_, tmp, total;
    int unsigned ua, ub;
    logic [15:0] rr;
    logic        cc, vv;
    total = 0;
    for (int i = 0; i < 16; i++) total += int'($signed(va[16*i +: 16]));
    r = '0;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      sa  = int'($signed(va[16*i +: 16]));
      ua  = int'(va[16*i +: 16]);
      sb_ = fs ? int'($signed(vb[15:0])) : int'($signed(vb[16*i +: 16]));
      ub  = fs ? int'(vb[15:0]) : int'(vb[16*i +: 16]);
      rr  = '0;
      cc  = 1'b0;
      vv  = 1'b0;
      case (op)
        3'd0: begin
          tmp = sa * sb_;
          rr  = tmp[23:8];
          vv  = (tmp < -8388608 || tmp > 8388607);
        end
        3'd1: begin
          tmp = sa - sb_;
          rr  = tmp[15:0];
          cc  = (ua < ub);
          vv  = !in_range16(tmp);
        end
        3'd2: begin
          tmp = sa + sb_;
          rr  = tmp[15:0];
          cc  = (ua + ub > 65535);
          vv  = !in_range16(tmp);
        end
        3'd3: begin
          if (i == 0) begin
            rr = total[15:0];
            vv = !in_range16(total);
          end
        end
        3'd4:    rr = va[16*i +: 16];
        3'd7:    rr = vc;
        default: rr = '0;
      endcase
      r[16*i +: 16] = rr;
      f[4*i +: 4]   = {rr[15], rr == 16'd0, cc, vv};
    end
  endfunction

  task automatic drive(input logic r_in, input logic [255:0] va, input logic [255:0] vb,
                       input logic [15:0] vc, input logic [2:0] op, input logic fs,
                       input string tag);
    exp_t e;
    @(negedge clk);
    rst         = r_in;
    a           = va;
    b           = vb;
    c           = vc;
    opcode      = op;
    flag_scalar = fs;
    if (r_in) begin
      e.r = '0;
      e.f = '0;
    end else begin
      model(va, vb, vc, op, fs, e.r, e.f);
    end
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Each entry is due exactly one edge after it was driven.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".result"}, result, e.r);
      check_eq({e.tag, ".flags"}, {192'd0, flags}, {192'd0, e.f});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [255:0] ta, tb_v, ra, rb, ov_a, ov_b;
  logic [15:0]  rc;

  initial begin
    ta   = 256'h0180_0140_0380_0180_0080_0300_0140_0000_0000_0000_0000_0000_0000_0000_0000_0140;
    tb_v = 256'hFE40_0180_0200_0340_05C0_FF80_FE80_0000_0000_0000_0000_0000_0000_0000_0000_FE80;
    ov_a = {ta[255:16], 16'h7F00};
    ov_b = {tb_v[255:16], 16'h0200};
    rst = 1'b1; a = '0; b = '0; c = '0; opcode = '0; flag_scalar = 1'b0;

    drive(1'b1, ta, tb_v, 16'h0, 3'd0, 1'b0, "reset0");
    drive(1'b1, ta, tb_v, 16'h0, 3'd2, 1'b0, "reset1");
    drive(1'b0, ta, tb_v, 16'h0, 3'd0, 1'b0, "mul_vec");
    drive(1'b0, ta, tb_v, 16'h0, 3'd0, 1'b1, "mul_scl");
    drive(1'b0, ta, tb_v, 16'h0, 3'd2, 1'b0, "add_vec");
    drive(1'b0, ta, tb_v, 16'h0, 3'd2, 1'b1, "add_scl");
    drive(1'b0, ta, tb_v, 16'hFF00, 3'd7, 1'b1, "set");
    drive(1'b0, ta, tb_v, 16'h0, 3'd3, 1'b1, "sum");
    drive(1'b0, ta, tb_v, 16'h0, 3'd1, 1'b0, "sub_vec");
    drive(1'b0, ta, tb_v, 16'h0, 3'd1, 1'b1, "sub_scl");
    drive(1'b0, ta, tb_v, 16'h0, 3'd4, 1'b0, "mov");
    drive(1'b0, ta, tb_v, 16'h1234, 3'd5, 1'b0, "rsv5");
    drive(1'b0, ta, tb_v, 16'h1234, 3'd6, 1'b1, "rsv6");
    drive(1'b0, ov_a, ov_b, 16'h0, 3'd0, 1'b0, "mul_ovf");
    drive(1'b1, ov_a, ov_b, 16'h0, 3'd0, 1'b0, "mid_reset");
    drive(1'b0, ov_a, ov_b, 16'h0, 3'd0, 1'b0, "after_reset");
    drive(1'b0, {16{16'h8000}}, {16{16'h8000}}, 16'h0, 3'd2, 1'b0, "add_min");
    drive(1'b0, {16{16'h8000}}, {16{16'h0001}}, 16'h0, 3'd1, 1'b0, "sub_min");
    drive(1'b0, {16{16'h8000}}, {16{16'h8000}}, 16'h0, 3'd0, 1'b0, "mul_min");
    drive(1'b0, {16{16'h7FFF}}, {16{16'h0001}}, 16'h0, 3'd2, 1'b0, "add_max");
    drive(1'b0, {16{16'h7FFF}}, {16{16'h0000}}, 16'h0, 3'd3, 1'b0, "sum_ovf");
    drive(1'b0, {16{16'h8000}}, {16{16'h0000}}, 16'h0, 3'd3, 1'b0, "sum_neg");

    for (int k = 0; k < 60; k++) begin
      for (int w = 0; w < 8; w++) begin
        ra[32*w +: 32] = $urandom;
        rb[32*w +: 32] = $urandom;
      end
      rc = 16'($urandom);
      drive(1'b0, ra, rb, rc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
    end

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("drain", 256'(sb.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
